// File: rtl/hs_pkg.sv
// Shared handshake package: pointer-width helper and common
// defaults used by the valid/ready channel blocks.
package hs_pkg;

    localparam int HS_DATA_WIDTH = 8;
    localparam int HS_DEPTH      = 4;

    // Pointer width with one extra wrap bit above the address.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/handshake_fifo_mem.sv
// Storage array for handshake_fifo: sync write, async read, no reset.
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port.
module handshake_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/handshake_fifo.sv
// Valid/ready FIFO with occupancy count and almost-full flag.
// Ports: clk, rst (async active-low), s_* write side, m_* read side,
//        count, almost_full, empty status outputs.
module handshake_fifo
    import hs_pkg::*;
#(
    parameter int DATA_WIDTH  = HS_DATA_WIDTH,
    parameter int DEPTH       = HS_DEPTH,
    parameter int AFULL_LEVEL = DEPTH - 1,
    localparam int PW         = ptr_w(DEPTH),
    localparam int AW         = PW - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [PW-1:0]         count,
    output logic                  almost_full,
    output logic                  empty
);

    localparam logic [PW-1:0] AF_LVL = PW'(AFULL_LEVEL);

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  init_done;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] rd_data;

    // Same slot, opposite lap: full. Same slot, same lap: empty.
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                   (wr_ptr[PW-1] != rd_ptr[PW-1]);
    assign empty = (wr_ptr == rd_ptr);

    // s_ready looks only at local state, never at m_ready.
    assign s_ready = !full && init_done;
    assign m_valid = !empty;
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;

    assign m_data      = empty ? '0 : rd_data;
    assign almost_full = (count >= AF_LVL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case (1'b1)
                push && !pop: count <= count + 1'b1;
                pop && !push: count <= count - 1'b1;
                default:      count <= count;
            endcase
        end
    end

    handshake_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (s_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_handshake_fifo.sv
// Scoreboard bench for handshake_fifo: directed cases plus a random
// stream, checked against a queue model sampled on the falling edge.
module tb_handshake_fifo;

    localparam int DW = 8;
    localparam int DEPTH = 4;
    localparam int AFL = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic [2:0]    count;
    logic          almost_full;
    logic          empty;

    int checks = 0;
    int errors = 0;
    int edges = 0;
    logic [DW-1:0] q[$];

    handshake_fifo #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .AFULL_LEVEL (AFL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .count       (count),
        .almost_full (almost_full),
        .empty       (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Edges seen since reset release; writes open after the first.
    always @(posedge clk or negedge rst) begin
        if (!rst) edges <= 0;
        else if (edges < 2) edges <= edges + 1;
    end

    // Monitor: compare outputs with the queue model, then apply
    // the handshakes that the coming rising edge will perform.
    logic          hold_prev = 1'b0;
    logic [DW-1:0] data_prev = '0;
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_s_ready", s_ready, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_m_data", m_data, 0);
            chk("rst_count", count, 0);
            chk("rst_empty", empty, 1);
            chk("rst_afull", almost_full, 0);
            q.delete();
            hold_prev = 1'b0;
        end else begin
            chk("m_valid", m_valid, q.size() != 0);
            chk("count", count, q.size());
            chk("count_max", count <= DEPTH, 1);
            chk("empty", empty, q.size() == 0);
            chk("afull", almost_full, q.size() >= AFL);
            chk("s_ready", s_ready, (edges >= 1) && (q.size() < DEPTH));
            if (q.size() != 0) chk("m_data", m_data, q[0]);
            else chk("m_data_idle", m_data, 0);
            if (hold_prev && s_valid && s_data !== data_prev) begin
                checks++;
                errors++;
                $display("FAIL s_stable: got %0h expected %0h",
                         s_data, data_prev);
            end
            hold_prev = s_valid && !s_ready;
            data_prev = s_data;
            if (m_valid && m_ready && q.size() != 0) void'(q.pop_front());
            if (s_valid && s_ready) q.push_back(s_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int sent;
        int cyc;
        logic hs;

        rst = 1'b0;
        s_valid = 1'b1;
        s_data = 8'h5A;
        m_ready = 1'b0;
        repeat (3) step();
        chk("rst_hold_s_ready", s_ready, 0);
        rst = 1'b1;
        s_valid = 1'b0;
        chk("rel_s_ready0", s_ready, 0);
        step();
        chk("rel_s_ready1", s_ready, 1);

        // Single word
        s_valid = 1'b1;
        s_data = 8'hA5;
        step();
        s_valid = 1'b0;
        chk("one_m_valid", m_valid, 1);
        chk("one_m_data", m_data, 8'hA5);
        chk("one_count", count, 1);
        chk("one_empty", empty, 0);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("one_pop_count", count, 0);
        chk("one_pop_empty", empty, 1);

        // Fill and almost-full
        s_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            s_data = DW'(i);
            step();
            if (i == 2) chk("fill_af_lo", almost_full, 0);
            if (i == 3) chk("fill_af_hi", almost_full, 1);
        end
        chk("fill_s_ready", s_ready, 0);
        s_data = 8'h05;
        step();
        chk("fill_5th_ignored", count, 4);
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (4) step();
        m_ready = 1'b0;
        chk("fill_drained", empty, 1);

        // Full with simultaneous offer
        s_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            s_data = DW'(i);
            step();
        end
        s_data = 8'h55;
        m_ready = 1'b1;
        chk("fo_front", m_data, 8'h01);
        step();
        chk("fo_pop_count", count, 3);
        chk("fo_s_ready", s_ready, 1);
        chk("fo_next", m_data, 8'h02);
        m_ready = 1'b0;
        step();
        s_valid = 1'b0;
        chk("fo_refill_count", count, 4);
        m_ready = 1'b1;
        repeat (4) step();
        m_ready = 1'b0;
        chk("fo_drained", empty, 1);

        // Random streaming
        sent = 0;
        cyc = 0;
        while (sent < 100 && cyc < 3000) begin
            if (!s_valid && $urandom_range(1, 0) == 1) begin
                s_valid = 1'b1;
                s_data = DW'($urandom);
            end
            m_ready = ($urandom_range(1, 0) == 1);
            @(negedge clk);
            hs = s_valid && s_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (hs) begin
                sent++;
                s_valid = 1'b0;
            end
        end
        chk("stream_sent", sent, 100);
        s_valid = 1'b0;
        m_ready = 1'b1;
        cyc = 0;
        while (!empty && cyc < 50) begin
            step();
            cyc++;
        end
        m_ready = 1'b0;
        chk("stream_drained", empty, 1);
        chk("stream_model_empty", q.size(), 0);

        // Mid-stream reset
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = 8'hC0 + DW'(i);
            step();
        end
        s_valid = 1'b0;
        chk("mr_count3", count, 3);
        #3;
        rst = 1'b0;
        #1;
        chk("mr_m_valid", m_valid, 0);
        chk("mr_count", count, 0);
        chk("mr_empty", empty, 1);
        chk("mr_s_ready", s_ready, 0);
        chk("mr_m_data", m_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        s_valid = 1'b1;
        s_data = 8'h77;
        step();
        chk("mr_first", m_data, 8'h77);
        s_data = 8'h78;
        step();
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (2) step();
        m_ready = 1'b0;
        chk("mr_drained", empty, 1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
